cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Initiator-side controller for the byte-addressable, 16-bit word main memory (word address = addr[15:1]; one access per cycle; no concurrent read and write).
- On a cache miss, issues WORDS_PER_BLOCK pipelined word reads and writes each returned word into the cache data array.
- Also issues single-word write-through stores.
- Sits between the cache/pipeline stall logic and the memory; it is the only block that drives the memory request pins.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  1  level; held high until fill_done.
- miss_addr  in  ADDR_WIDTH  byte address of the missing word; must be stable while miss_req is high.
- wr_req  in  1  write-through request; held high until wr_ack.
- wr_addr  in  ADDR_WIDTH  store byte address; bit 0 ignored.
- wr_data  in  16  store data.
- wr_ack  out  1  one-cycle pulse: store issued.
- fill_done  out  1  one-cycle pulse: block fully written to cache.
- busy  out  1  high in any state other than IDLE.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory byte address; bit 0 always 0.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data.
- mem_data_valid  in  1  read data valid; returns in issue order.
- cache_we  out  1  cache data-array write enable.
- cache_addr  out  ADDR_WIDTH  cache byte address of the word being written.
- cache_wdata  out  16  word to write into the cache.
- tag_we  out  1  tag/valid write; pulses together with fill_done.

Behaviour:
- Reset (asynchronous): state returns to IDLE and counters clear. All outputs reset to 0.
- Memory-side outputs (mem_*) are registered (Moore outputs).
- Cache-side outputs (cache_we, cache_addr, cache_wdata) are combinational from mem_data_valid and the receive counter: zero added latency.
- States: IDLE, WRITE, FILL, DRAIN, DONE.
- IDLE:
  - If wr_req is high, go to WRITE. wr_req has priority over miss_req when both are high in the same cycle.
  - Else if miss_req is high, latch base = miss_addr with bits [log2(WORDS_PER_BLOCK):0] cleared, clear issue_cnt and rcv_cnt, and go to FILL.
  - mem_enable is 0 in IDLE.
- WRITE (exactly 1 cycle):
  - mem_enable=1, mem_wr=1, mem_addr={wr_addr[15:1],0}, mem_data_in=wr_data, wr_ack=1.
  - Next state is IDLE. The requester drops wr_req on the edge that ends WRITE.
- FILL:
  - Each cycle: mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments.
  - After the cycle with issue_cnt=WORDS_PER_BLOCK-1, go to DRAIN, or directly to DONE if the last valid arrives in that same cycle.
- FILL and DRAIN, on each mem_data_valid:
  - cache_we=1, cache_addr=base+2*rcv_cnt, cache_wdata=mem_data_out; rcv_cnt increments.
  - When rcv_cnt=WORDS_PER_BLOCK-1 and valid is high, the next state is DONE.
- DRAIN: mem_enable=0; wait for the remaining valids.
- DONE (1 cycle): fill_done=1, tag_we=1; next state is IDLE.
- mem_data_valid in IDLE, WRITE or DONE is ignored (no cache_we). This covers stale data after a reset mid-fill.
- Address arithmetic is modulo 2^ADDR_WIDTH; a block at the top of memory does not wrap into the next block.
- Memory read and write are never issued in the same cycle: mem_wr=1 occurs only in WRITE.
- wr_req arriving during FILL or DRAIN waits: it is serviced in IDLE after DONE. Its wait time appears through busy.
- rst mid-fill: the partial block is abandoned. tag_we is never asserted for it, so the cache line stays invalid.

Optional Feature:
- CRITICAL_WORD_FIRST_EN
  - Defined: issue and receive order start at the missing word w0=miss_addr[log2(WORDS_PER_BLOCK):1] and wrap modulo WORDS_PER_BLOCK within the block. The address is base+2*((w0+cnt) mod WORDS_PER_BLOCK) for both mem_addr and cache_addr. An extra output crit_valid pulses with the first cache_we of the fill.
  - Undefined: fills always run from word 0, and the crit_valid port is absent.

Decomposition:
- Shared package cache_pkg holds:
  - state enum fill_state_t;
  - WORD_BYTES=2;
  - localparam OFFSET_BITS=$clog2(WORDS_PER_BLOCK)+1;
  - a function for the block-base mask.
- One natural sub-module: fill_addr_gen. It takes base, a counter and w0, and produces a wrapped byte address. It is instantiated twice, once for issue and once for receive.

Test Plan:
- Reset then idle: assert rst mid-cycle → all outputs 0 immediately (asynchronous). Inject valids while idle → no cache_we.
- Fill with a 4-cycle-latency memory: miss_addr=0x1236 → mem_addr 0x1230..0x123E on 8 consecutive cycles; 8 cache_we to 0x1230..0x123E with matching data; then one fill_done+tag_we pulse.
- Write and miss together: wr_req (0x0042, 0xBEEF) and miss_req in the same cycle → WRITE first (mem_wr=1, mem_addr 0x0042, wr_ack pulse), then the fill starts the next cycle.
- Write during fill: wr_req during DRAIN → no mem_wr until after fill_done; wr_ack follows within 2 cycles.
- Reset mid-fill: rst after 3 valids → IDLE, tag_we never asserted. A fresh miss to 0x2000 then completes normally.
- CRITICAL_WORD_FIRST_EN: miss_addr=0x123A → mem_addr order 0x123A, 0x123C, 0x123E, 0x1230...0x1238; crit_valid pulses with the 0x123A write.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache block-fill controller:
//   - fill_state_t    : controller state encoding
//   - WORD_BYTES      : bytes per memory word (16-bit words)
//   - OFFSET_BITS     : byte-offset width of a block for the default geometry
//   - block_base_mask : mask that clears the in-block byte offset
// Optional build macro used by the importing RTL: CRITICAL_WORD_FIRST_EN
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_FILL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } fill_state_t;

    localparam int WORD_BYTES              = 2;
    localparam int DEFAULT_WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS             = $clog2(DEFAULT_WORDS_PER_BLOCK) + 1;

    // Ones everywhere except the low offset_bits positions.
    function automatic logic [31:0] block_base_mask(input int offset_bits);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        return ones << offset_bits;
    endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// -----------------------------------------------------------------------------
// fill_addr_gen
// Produces the byte address of one word inside a cache block:
//   addr_o = base_i + 2 * ((w0_i + cnt_i) mod 2^CNT_W)
// The word index wraps inside the block, so the carry never reaches the
// block-base bits. Driving w0_i with zero gives a plain linear walk.
// Ports:
//   base_i [ADDR_WIDTH] block-aligned byte address
//   cnt_i  [CNT_W]      word counter
//   w0_i   [CNT_W]      starting word index
//   addr_o [ADDR_WIDTH] resulting byte address (bit 0 always 0)
// -----------------------------------------------------------------------------
module fill_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [CNT_W-1:0]      cnt_i,
    input  logic [CNT_W-1:0]      w0_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [CNT_W-1:0]      idx_s;
    logic [ADDR_WIDTH-1:0] off_s;

    // Wrapped word index placed above the byte-select bit.
    always_comb begin
        idx_s            = w0_i + cnt_i;
        off_s            = '0;
        off_s[CNT_W:1]   = idx_s;
        addr_o           = base_i + off_s;
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Initiator-side controller for a 16-bit-word main memory. On a miss it issues
// WORDS_PER_BLOCK pipelined word reads and writes each returned word into the
// cache data array; it also issues single-word write-through stores.
// Build macro: CRITICAL_WORD_FIRST_EN -- fills start at the missing word and
// wrap within the block; adds the crit_valid output.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   miss_req/miss_addr  block-fill request (held until fill_done)
//   wr_req/wr_addr/wr_data  write-through store (held until wr_ack)
//   wr_ack, fill_done   one-cycle completion pulses
//   busy                high whenever not IDLE
//   mem_*               registered memory request pins, read data return
//   cache_we/addr/wdata combinational cache data-array write port
//   tag_we              tag/valid write, coincident with fill_done
//   crit_valid          (macro only) first cache write of a fill
// -----------------------------------------------------------------------------
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    output logic                  wr_ack,
    output logic                  fill_done,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    input  logic                  mem_data_valid,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [15:0]           cache_wdata,
    output logic                  tag_we
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                  crit_valid
`endif
);

    localparam int CNT_W    = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_BITS = CNT_W + $clog2(WORD_BYTES);
    localparam logic [31:0]           MASK32    = block_base_mask(OFF_BITS);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = MASK32[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] HALF_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

    fill_state_t           state_q, state_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      rcv_cnt_q, rcv_cnt_d;
    logic [CNT_W-1:0]      w0_q, w0_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    logic                  mem_enable_d, mem_wr_d, wr_ack_d;
    logic                  fill_done_d, tag_we_d, busy_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [15:0]           mem_data_in_d;

    logic [ADDR_WIDTH-1:0] issue_addr_s, rcv_addr_s;
    logic                  rcv_fire_s;

    // Returned data only counts while a fill is in flight; stale data after a
    // reset, or stray valids in IDLE/WRITE/DONE, are dropped here.
    assign rcv_fire_s = mem_data_valid && ((state_q == S_FILL) || (state_q == S_DRAIN));

    // Issue address is computed from the next-cycle counter so that the
    // registered mem_addr lines up with the FILL cycle that issues it.
    fill_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CNT_W)
    ) u_issue_addr (
        .base_i (base_d),
        .cnt_i  (issue_cnt_d),
        .w0_i   (w0_d),
        .addr_o (issue_addr_s)
    );

    fill_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CNT_W)
    ) u_rcv_addr (
        .base_i (base_q),
        .cnt_i  (rcv_cnt_q),
        .w0_i   (w0_q),
        .addr_o (rcv_addr_s)
    );

    // Next-state, counter and block-base logic.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        base_d      = base_q;
        w0_d        = w0_q;
        if (rcv_fire_s) begin
            rcv_cnt_d = rcv_cnt_q + CNT_ONE;
        end else begin
            rcv_cnt_d = rcv_cnt_q;
        end
        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    state_d = S_WRITE;
                end else if (miss_req) begin
                    state_d     = S_FILL;
                    base_d      = miss_addr & BASE_MASK;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
`ifdef CRITICAL_WORD_FIRST_EN
                    w0_d        = miss_addr[OFF_BITS-1:1];
`else
                    w0_d        = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_FILL: begin
                // Last word may return in the same cycle as the last issue.
                if (rcv_fire_s && (rcv_cnt_q == LAST_CNT)) begin
                    state_d = S_DONE;
                end else if (issue_cnt_q == LAST_CNT) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d     = S_FILL;
                    issue_cnt_d = issue_cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (rcv_fire_s && (rcv_cnt_q == LAST_CNT)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state, registered below.
    always_comb begin
        mem_enable_d  = 1'b0;
        mem_wr_d      = 1'b0;
        mem_addr_d    = '0;
        mem_data_in_d = 16'h0000;
        wr_ack_d      = 1'b0;
        fill_done_d   = 1'b0;
        tag_we_d      = 1'b0;
        case (state_d)
            S_WRITE: begin
                mem_enable_d  = 1'b1;
                mem_wr_d      = 1'b1;
                mem_addr_d    = wr_addr & HALF_MASK;
                mem_data_in_d = wr_data;
                wr_ack_d      = 1'b1;
            end
            S_FILL: begin
                mem_enable_d = 1'b1;
                mem_addr_d   = issue_addr_s;
            end
            S_DONE: begin
                fill_done_d = 1'b1;
                tag_we_d    = 1'b1;
            end
            default: begin
                mem_enable_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            w0_q        <= '0;
            base_q      <= '0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= 16'h0000;
            wr_ack      <= 1'b0;
            fill_done   <= 1'b0;
            tag_we      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            w0_q        <= w0_d;
            base_q      <= base_d;
            mem_enable  <= mem_enable_d;
            mem_wr      <= mem_wr_d;
            mem_addr    <= mem_addr_d;
            mem_data_in <= mem_data_in_d;
            wr_ack      <= wr_ack_d;
            fill_done   <= fill_done_d;
            tag_we      <= tag_we_d;
            busy        <= busy_d;
        end
    end

    // Cache write port: zero-latency pass-through of returned words.
    always_comb begin
        cache_we = rcv_fire_s;
        if (rcv_fire_s) begin
            cache_addr  = rcv_addr_s;
            cache_wdata = mem_data_out;
        end else begin
            cache_addr  = '0;
            cache_wdata = 16'h0000;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    assign crit_valid = rcv_fire_s && (rcv_cnt_q == '0);
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;

    logic        clk;
    logic        rst;
    logic        miss_req;
    logic [15:0] miss_addr;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        fill_done;
    logic        busy;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        cache_we;
    logic [15:0] cache_addr;
    logic [15:0] cache_wdata;
    logic        tag_we;
`ifdef CRITICAL_WORD_FIRST_EN
    logic        crit_valid;
`endif

    cache_fill_ctrl #(
        .ADDR_WIDTH      (16),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_req       (miss_req),
        .miss_addr      (miss_addr),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .fill_done      (fill_done),
        .busy           (busy),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .cache_we       (cache_we),
        .cache_addr     (cache_addr),
        .cache_wdata    (cache_wdata),
        .tag_we         (tag_we)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid     (crit_valid)
`endif
    );

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        crit;
    } cw_t;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } pipe_t;

    ev_t   ev_q[$];
    cw_t   cw_q[$];
    ev_t   mon_e;
    cw_t   mon_c;
    int    checks   = 0;
    int    failures = 0;

    // memory model controls
    logic  inj;
    logic  lat0;
    int    lat;
    logic  cap_v;
    logic [15:0] cap_a;
    pipe_t pipe [4];

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read/done events and cache writes for one block fill.
    task automatic push_fill(input logic [15:0] a);
        logic [15:0] base;
        logic [2:0]  w0;
        logic [2:0]  idx;
        ev_t e;
        cw_t c;
        base = a & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
        w0 = a[3:1];
`else
        w0 = 3'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            idx    = w0 + 3'(i);
            e.kind = K_RD;
            e.addr = base + {12'd0, idx, 1'b0};
            e.data = 16'h0000;
            ev_q.push_back(e);
            c.addr = e.addr;
            c.data = memf(e.addr);
            c.crit = (i == 0);
            cw_q.push_back(c);
        end
        e.kind = K_DONE;
        e.addr = 16'h0000;
        e.data = 16'h0000;
        ev_q.push_back(e);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = K_WR;
        e.addr = a;
        e.data = d;
        ev_q.push_back(e);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!fill_done && cyc < budget);
        if (!fill_done) begin
            checks++;
            failures++;
            $display("FAIL timeout_fill_done waited=%0d", cyc);
        end
    endtask

    task automatic wait_ack(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wr_ack && cyc < budget);
        if (!wr_ack) begin
            checks++;
            failures++;
            $display("FAIL timeout_wr_ack waited=%0d", cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},        busy,        1'b0);
        chk({tag, "_mem_enable"},  mem_enable,  1'b0);
        chk({tag, "_mem_wr"},      mem_wr,      1'b0);
        chk({tag, "_mem_addr"},    mem_addr,    16'h0000);
        chk({tag, "_mem_data_in"}, mem_data_in, 16'h0000);
        chk({tag, "_wr_ack"},      wr_ack,      1'b0);
        chk({tag, "_fill_done"},   fill_done,   1'b0);
        chk({tag, "_tag_we"},      tag_we,      1'b0);
        chk({tag, "_cache_we"},    cache_we,    1'b0);
        chk({tag, "_cache_addr"},  cache_addr,  16'h0000);
        chk({tag, "_cache_wdata"}, cache_wdata, 16'h0000);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    // memory: capture request mid-cycle
    initial begin
        cap_v = 1'b0;
        cap_a = 16'h0000;
        forever begin
            @(negedge clk);
            cap_v = mem_enable && !mem_wr;
            cap_a = mem_addr;
        end
    end

    // memory: return data lat cycles later (or same cycle in lat0 mode)
    initial begin
        mem_data_valid = 1'b0;
        mem_data_out   = 16'h0000;
        for (int i = 0; i < 4; i++) pipe[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0].v = cap_v;
            pipe[0].d = memf(cap_a);
            if (inj) begin
                mem_data_valid = 1'b1;
                mem_data_out   = 16'hDEAD;
            end else if (lat0) begin
                mem_data_valid = mem_enable && !mem_wr;
                mem_data_out   = memf(mem_addr);
            end else begin
                mem_data_valid = pipe[lat-1].v;
                mem_data_out   = pipe[lat-1].d;
            end
        end
    end

    // monitor: pop expected events whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_enable || fill_done) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event en=%b wr=%b done=%b addr=%h", mem_enable, mem_wr, fill_done, mem_addr);
                end else begin
                    mon_e = ev_q.pop_front();
                    chk("event_kind", fill_done ? K_DONE : (mem_wr ? K_WR : K_RD), mon_e.kind);
                    if (mon_e.kind != K_DONE) chk("mem_addr", mem_addr, mon_e.addr);
                    if (mon_e.kind == K_WR) chk("mem_data_in", mem_data_in, mon_e.data);
                end
            end
            if (cache_we) begin
                if (cw_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cache_we addr=%h data=%h", cache_addr, cache_wdata);
                end else begin
                    mon_c = cw_q.pop_front();
                    chk("cache_addr", cache_addr, mon_c.addr);
                    chk("cache_wdata", cache_wdata, mon_c.data);
`ifdef CRITICAL_WORD_FIRST_EN
                    chk("crit_valid", crit_valid, mon_c.crit);
`endif
                end
            end
`ifdef CRITICAL_WORD_FIRST_EN
            chk("crit_without_we", crit_valid & ~cache_we, 1'b0);
`endif
            chk("tag_we_with_done", tag_we, fill_done);
            chk("wr_ack_with_write", wr_ack, mem_enable & mem_wr);
            chk("mem_wr_needs_en", mem_wr & ~mem_enable, 1'b0);
        end
    end

    initial begin
        int n;
        int vcnt;
        int stale;
        rst       = 1'b1;
        miss_req  = 1'b0;
        miss_addr = 16'h0000;
        wr_req    = 1'b0;
        wr_addr   = 16'h0000;
        wr_data   = 16'h0000;
        inj       = 1'b0;
        lat0      = 1'b0;
        lat       = 4;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // stray valids while idle must not write the cache
        inj = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_inj_valid", mem_data_valid, 1'b1);
            chk("idle_no_cache_we", cache_we, 1'b0);
            chk("idle_not_busy", busy, 1'b0);
        end
        inj = 1'b0;
        repeat (2) @(negedge clk);

        // basic fill, 4-cycle memory
        miss_addr = 16'h1236;
        miss_req  = 1'b1;
        push_fill(16'h1236);
        wait_done(40, n);
        miss_req = 1'b0;
        chk("fill_1236_cycles", n, 13);
        repeat (2) @(negedge clk);

        // critical-word test address (linear when feature disabled)
        miss_addr = 16'h123A;
        miss_req  = 1'b1;
        push_fill(16'h123A);
        wait_done(40, n);
        miss_req = 1'b0;
        chk("fill_123A_cycles", n, 13);
        repeat (2) @(negedge clk);

        // top-of-memory block, 2-cycle memory
        lat       = 2;
        miss_addr = 16'hFFF8;
        miss_req  = 1'b1;
        push_fill(16'hFFF8);
        wait_done(40, n);
        miss_req = 1'b0;
        chk("fill_top_cycles", n, 11);
        repeat (6) @(negedge clk);

        // same-cycle memory: last valid with last issue goes straight to DONE
        lat0      = 1'b1;
        miss_addr = 16'h0A2E;
        miss_req  = 1'b1;
        push_fill(16'h0A2E);
        wait_done(40, n);
        miss_req = 1'b0;
        chk("fill_lat0_cycles", n, 9);
        lat0 = 1'b0;
        lat  = 4;
        repeat (6) @(negedge clk);

        // write and miss in the same cycle: write first
        wr_req    = 1'b1;
        wr_addr   = 16'h0042;
        wr_data   = 16'hBEEF;
        miss_req  = 1'b1;
        miss_addr = 16'h0100;
        push_wr(16'h0042, 16'hBEEF);
        push_fill(16'h0100);
        wait_ack(10, n);
        wr_req = 1'b0;
        chk("wr_ack_latency", n, 1);
        wait_done(40, n);
        miss_req = 1'b0;
        chk("fill_after_write_cycles", n, 14);
        repeat (2) @(negedge clk);

        // write arriving during DRAIN waits until after fill_done
        miss_addr = 16'h3456;
        miss_req  = 1'b1;
        push_fill(16'h3456);
        repeat (10) @(negedge clk);
        chk("drain_busy", busy, 1'b1);
        chk("drain_no_issue", mem_enable, 1'b0);
        wr_req  = 1'b1;
        wr_addr = 16'h0043;
        wr_data = 16'h1234;
        push_wr(16'h0042, 16'h1234);
        wait_done(40, n);
        miss_req = 1'b0;
        wait_ack(10, n);
        wr_req = 1'b0;
        chk("wr_ack_after_done", n, 2);
        repeat (2) @(negedge clk);

        // reset after 3 valids abandons the block
        miss_addr = 16'h5550;
        miss_req  = 1'b1;
        push_fill(16'h5550);
        vcnt = 0;
        n    = 0;
        while (vcnt < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_data_valid) vcnt++;
        end
        chk("midfill_valids_seen", vcnt, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        ev_q.delete();
        cw_q.delete();
        miss_req = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_no_tag_we", tag_we, 1'b0);
            if (mem_data_valid) begin
                stale++;
                chk("stale_no_cache_we", cache_we, 1'b0);
            end
        end
        chk("stale_valids_seen", (stale != 0), 1'b1);

        // fresh miss after the abandoned fill
        miss_addr = 16'h2000;
        miss_req  = 1'b1;
        push_fill(16'h2000);
        wait_done(40, n);
        miss_req = 1'b0;
        chk("fill_2000_cycles", n, 13);

        repeat (4) @(negedge clk);
        chk("events_drained", ev_q.size(), 0);
        chk("cache_writes_drained", cw_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
